// File: rtl/alu_op_decoder.sv
// RV32I instruction-to-ALU decoder with a two-entry output/skid buffer.
// Decode is combinational from the input word; only the buffered bundles are registered.
module alu_op_decoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_alu_f,
    output logic [1:0]  o_a_sel,
    output logic        o_b_sel,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rd,
    output logic        o_rd_wren,
    output logic        o_illegal,
    output logic [31:0] o_pc
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    typedef struct packed {
        logic [3:0]  alu_f;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_wren;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    state_t  state_q, state_d;
    bundle_t out_q, skid_q, dec;
    logic    load_out, load_skid, skid_to_out;
    logic    acc, drn, legal;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'h000};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.rd      = i_instr[11:7];
        dec.pc      = i_pc;
        legal       = 1'b1;
        unique case (opcode)
            OPC_OP: begin
                dec.alu_f   = {i_instr[30], funct3};
                dec.rd_wren = 1'b1;
                legal       = (funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.alu_f   = {1'b0, funct3};
                dec.b_sel   = 1'b1;
                dec.imm     = imm_i;
                dec.rd_wren = 1'b1;
                if (funct3 == 3'b101) begin
                    dec.alu_f[3] = i_instr[30];
                    legal        = (funct7 == 7'h00) || (funct7 == 7'h20);
                end else if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'h00);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec.b_sel   = 1'b1;
                dec.imm     = imm_i;
                dec.rd_wren = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel = 1'b1;
                dec.imm   = imm_s;
            end
            OPC_BRANCH: begin
                dec.a_sel = A_PC;
                dec.b_sel = 1'b1;
                dec.imm   = imm_b;
            end
            OPC_JAL: begin
                dec.a_sel   = A_PC;
                dec.b_sel   = 1'b1;
                dec.imm     = imm_j;
                dec.rd_wren = 1'b1;
            end
            OPC_LUI: begin
                dec.a_sel   = A_ZERO;
                dec.b_sel   = 1'b1;
                dec.imm     = imm_u;
                dec.rd_wren = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel   = A_PC;
                dec.b_sel   = 1'b1;
                dec.imm     = imm_u;
                dec.rd_wren = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal words keep rd and pc so they still travel in order as a marked bundle.
        if (!legal) begin
            dec.alu_f   = '0;
            dec.a_sel   = A_RS1;
            dec.b_sel   = 1'b0;
            dec.imm     = '0;
            dec.rd_wren = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = (state_q != ST_TWO);
    assign acc     = i_valid & o_ready;
    assign drn     = o_valid & i_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d  = ST_ONE;
                    load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && !drn) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (!acc && drn) begin
                    state_d = ST_EMPTY;
                end else if (acc && drn) begin
                    load_out = 1'b1;
                end
            end
            ST_TWO: begin
                if (drn) begin
                    state_d     = ST_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= dec;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign o_alu_f   = out_q.alu_f;
    assign o_a_sel   = out_q.a_sel;
    assign o_b_sel   = out_q.b_sel;
    assign o_imm     = out_q.imm;
    assign o_rd      = out_q.rd;
    assign o_rd_wren = out_q.rd_wren;
    assign o_illegal = out_q.illegal;
    assign o_pc      = out_q.pc;

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Registered instruction-to-ALU decoder. Accepts RV32I instruction words with their PC over a valid/ready handshake and produces the 4-bit ALU function code, operand-select controls, the sign-extended immediate and writeback controls. It sits between fetch and execute and drives the ALU's `f`, operand-mux and immediate inputs. A two-entry output/skid buffer decouples upstream from downstream stalls with no bubbles.

## Interface

- No parameters. Widths are fixed by RV32I.
- `i_clk` in 1: clock. All state updates on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_valid` in 1: upstream has an instruction.
- `o_ready` out 1: decoder can accept an instruction. Reset 1.
- `i_instr` in 32: instruction word.
- `i_pc` in 32: PC of `i_instr`.
- `o_valid` out 1: decoded bundle valid. Reset 0.
- `i_ready` in 1: downstream accepts the bundle.
- `o_alu_f` out 4: ALU function code. Reset 0.
- `o_a_sel` out 2: operand A source: 00 rs1, 01 pc, 10 zero. Reset 0.
- `o_b_sel` out 1: operand B source: 0 rs2, 1 imm. Reset 0.
- `o_imm` out 32: sign-extended immediate. Reset 0.
- `o_rd` out 5: destination register. Reset 0.
- `o_rd_wren` out 1: register writeback enable. Reset 0.
- `o_illegal` out 1: unsupported encoding. Reset 0.
- `o_pc` out 32: PC passthrough. Reset 0.

## Operation

- **f encoding:** {bit3, funct3}. The low bits select the operation:
  - 000 add/sub
  - 001 sll
  - 010 slt
  - 011 sltu
  - 100 xor
  - 101 srl/sra
  - 110 or
  - 111 and

  Bit3 selects sub when funct3=000 and sra when funct3=101.
- **R-type (0110011):** f = {instr[30], funct3}; a=rs1, b=rs2, wren=1.
  - funct7 must be 0000000.
  - funct7 0100000 is allowed only with funct3 000 or 101.
  - Any other funct7 → illegal.
- **OP-IMM (0010011):** f = {0, funct3}; a=rs1, b=imm, wren=1.
  - funct3 101: f[3] = instr[30]; instr[31:25] must be 0000000 or 0100000, else illegal.
  - funct3 001: instr[31:25] must be 0000000, else illegal.
- **LOAD (0000011), JALR (1100111):** f=0000, a=rs1, b=imm(I), wren=1.
- **STORE (0100011):** f=0000, a=rs1, b=imm(S), wren=0.
- **BRANCH (1100011):** f=0000, a=pc, b=imm(B), wren=0. This computes the target address.
- **JAL (1101111):** f=0000, a=pc, b=imm(J), wren=1.
- **LUI (0110111):** f=0000, a=zero, b=imm(U), wren=1.
- **AUIPC (0010111):** f=0000, a=pc, b=imm(U), wren=1.
- **Immediates:** each is sign-extended from instr[31].
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'h0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- **Shift immediate:** shift instructions use the I immediate unchanged. The ALU consumes only bits [4:0].
- **Illegal instructions:** any other opcode, or a violated funct7 rule, produces o_illegal=1, f=0000, wren=0, a=00, b=0, imm=0. The instruction still flows through the buffer in order. o_rd = instr[11:7] for every instruction.
- **Buffer states:**
  - EMPTY: o_valid=0, o_ready=1.
  - ONE: output register full; o_valid=1, o_ready=1.
  - TWO: output register and skid register both full; o_valid=1, o_ready=0.
- **Transitions** (acc = i_valid & o_ready; drn = o_valid & i_ready):
  - EMPTY: acc → ONE.
  - ONE: acc & !drn → TWO. !acc & drn → EMPTY. acc & drn → ONE, with the output register loaded with the new bundle.
  - TWO: drn → ONE, skid moves to the output register. No accept is possible in TWO.
- **Ordering:** strict FIFO order. No bundle is dropped or duplicated.
- **o_ready:** a registered signal (= state != TWO) with no combinational path from i_ready.

## Timing

- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N when the buffer was EMPTY, or ONE and draining.
- Throughput is 1 instruction/cycle while i_ready=1.
- Outputs are stable while o_valid=1 & i_ready=0.
- i_rst_n low at any time, including mid-transfer:
  - State goes to EMPTY immediately.
  - All outputs take their reset values asynchronously.
  - Buffered bundles are discarded.
- First accept after reset release is on the first edge with i_valid=1.

## Test plan

- add x3,x1,x2 (0x002081B3), i_ready=1 → next cycle o_valid=1, f=0000, a=00, b=0, rd=3, wren=1, illegal=0.
- sub x5,x6,x7 (0x407302B3) → f=1000, rd=5. srai x1,x2,3 (0x40315093) → f=1101, b=1, imm=0x00000403.
- lui x10,0x12345 (0x12345537) → f=0000, a=10, b=1, imm=0x12345000, wren=1. sw x2,8(x1) (0x0020A423) → imm=0x00000008, b=1, wren=0.
- Illegal cases, each → illegal=1, f=0000, wren=0:
  - 0xFFFFFFFF.
  - R-type with funct7=0100000 and funct3=100 (0x4020C1B3).
- Backpressure: i_ready=0, present 3 instructions back-to-back.
  - o_ready goes 0 after 2 accepts; the third is held upstream.
  - Raise i_ready → the bundles exit in order over 3 consecutive cycles.
- Assert i_rst_n=0 mid-cycle while in TWO → o_valid=0 and o_ready=1 immediately. After release, the next instruction is decoded with no stale bundle.
